// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side operands and controls in, EX-side registered fields out.
// The driver side (ID/Control) uses modport master. The stage itself uses modport slave.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
);
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [REG_AW-1:0] rs_addr_i;
  logic [REG_AW-1:0] rt_addr_i;
  logic [REG_AW-1:0] rd_addr_i;
  logic              flush_i;
  logic              hold_i;
  logic              stall_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [DATA_W-1:0] ex_rs_data_o;
  logic [DATA_W-1:0] ex_rt_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [REG_AW-1:0] ex_rs_addr_o;
  logic [REG_AW-1:0] ex_rt_addr_o;
  logic [REG_AW-1:0] ex_dst_addr_o;
  logic              ex_valid_o;

  modport master (
    output ctrl_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i, flush_i, hold_i,
    input  stall_o, ex_ctrl_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_addr_o, ex_rt_addr_o,
           ex_dst_addr_o, ex_valid_o
  );

  modport slave (
    input  ctrl_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i, flush_i, hold_i,
    output stall_o, ex_ctrl_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_addr_o, ex_rt_addr_o,
           ex_dst_addr_o, ex_valid_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.
// On a load-use hazard or an IF/ID flush, a one-cycle bubble is inserted by zeroing the control bundle.
// Optional macro ID_EX_HAZ_STATS_EN adds saturating 16-bit stall and flush event counters.
// Control bit map: [0]ALUSrc [2:1]ALUOp [3]RegDst [4]MemRead [5]MemWrite [6]RegWrite [7]MemtoReg
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef ID_EX_HAZ_STATS_EN
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
`endif
  id_ex_stage_if.slave bus
);

  localparam int MEMREAD_BIT = 4;
  localparam int REGDST_BIT  = 3;

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_dst_addr;
  logic              r_valid;

  logic              w_haz;
  logic              w_bubble;
  logic [REG_AW-1:0] w_dst_next;

  // A load currently in EX whose nonzero destination feeds either ID source operand.
  // The ID opcode is deliberately ignored, so J-type instructions can stall spuriously.
  always_comb begin
    w_haz = r_ctrl[MEMREAD_BIT] & (r_dst_addr != '0) &
            ((r_dst_addr == bus.rs_addr_i) | (r_dst_addr == bus.rt_addr_i));
    w_bubble   = bus.flush_i | w_haz;
    w_dst_next = bus.ctrl_i[REGDST_BIT] ? bus.rd_addr_i : bus.rt_addr_i;
  end

  // A flush kills the ID instruction, so stalling for it would be pointless.
  assign bus.stall_o = w_haz & ~bus.flush_i;

  // Pipeline register. Priority is reset, then hold, then bubble, then a normal load.
  // Data fields load even on a bubble so that they stay deterministic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl     <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs_addr  <= '0;
      r_rt_addr  <= '0;
      r_dst_addr <= '0;
      r_valid    <= 1'b0;
    end else if (!bus.hold_i) begin
      r_rs_data  <= bus.rs_data_i;
      r_rt_data  <= bus.rt_data_i;
      r_imm      <= bus.imm_i;
      r_rs_addr  <= bus.rs_addr_i;
      r_rt_addr  <= bus.rt_addr_i;
      r_dst_addr <= w_dst_next;
      r_ctrl     <= w_bubble ? '0 : bus.ctrl_i;
      r_valid    <= ~w_bubble;
    end
  end

  assign bus.ex_ctrl_o     = r_ctrl;
  assign bus.ex_rs_data_o  = r_rs_data;
  assign bus.ex_rt_data_o  = r_rt_data;
  assign bus.ex_imm_o      = r_imm;
  assign bus.ex_rs_addr_o  = r_rs_addr;
  assign bus.ex_rt_addr_o  = r_rt_addr;
  assign bus.ex_dst_addr_o = r_dst_addr;
  assign bus.ex_valid_o    = r_valid;

`ifdef ID_EX_HAZ_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating event counters. Frozen cycles are not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_haz && !bus.flush_i && !bus.hold_i && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (bus.flush_i && !bus.hold_i && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
